// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill path: FSM state encoding and
// address-field width helpers used by the controller and the cache top.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VICTIM = 3'd1,
    ST_REQ    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_COMMIT = 3'd4
  } refill_state_e;

  localparam int ADDR_W = 32;
  localparam int BYTE_W = 2;

  // Index width for a field selecting one of `count` items (never below 1 bit).
  function automatic int idx_w(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  function automatic int tag_w(input int set_count, input int line_words);
    return ADDR_W - idx_w(set_count) - idx_w(line_words) - BYTE_W;
  endfunction

endpackage

// File: rtl/cache_refill_controller.sv
// Line refill controller: picks a victim way, fetches a line one word at a
// time with a single outstanding memory request, then commits the tag.
module cache_refill_controller
  import cache_pkg::*;
#(
  parameter int WAY_COUNT  = 2,
  parameter int SET_COUNT  = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          miss_req,
  input  logic [31:0]                                   miss_addr,
  output logic                                          miss_ready,
  output logic                                          done,
  input  logic                                          hit_valid,
  input  logic [idx_w(SET_COUNT)-1:0]                   hit_set,
  input  logic [idx_w(WAY_COUNT)-1:0]                   hit_way,
  output logic [idx_w(SET_COUNT)-1:0]                   rp_set,
  output logic [idx_w(WAY_COUNT)-1:0]                   rp_way,
  output logic                                          rp_read,
  output logic                                          rp_written,
  output logic                                          rp_taken,
  input  logic [idx_w(WAY_COUNT)-1:0]                   rp_replacement_way,
  input  logic                                          rp_ready,
  output logic                                          mem_req,
  output logic [31:0]                                   mem_addr,
  input  logic                                          mem_gnt,
  input  logic                                          mem_rvalid,
  input  logic [31:0]                                   mem_rdata,
  output logic                                          line_we,
  output logic [idx_w(SET_COUNT)-1:0]                   line_set,
  output logic [idx_w(WAY_COUNT)-1:0]                   line_way,
  output logic [idx_w(LINE_WORDS)-1:0]                  line_word,
  output logic [31:0]                                   line_wdata,
  output logic                                          tag_we,
  output logic [tag_w(SET_COUNT, LINE_WORDS)-1:0]       tag_value
);

  localparam int SET_W  = idx_w(SET_COUNT);
  localparam int WAY_W  = idx_w(WAY_COUNT);
  localparam int WORD_W = idx_w(LINE_WORDS);
  localparam int TAG_W  = tag_w(SET_COUNT, LINE_WORDS);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  refill_state_e     state_r;
  refill_state_e     state_nxt_s;
  logic [SET_W-1:0]  set_r;
  logic [TAG_W-1:0]  tag_r;
  logic [WAY_W-1:0]  way_r;
  logic [WORD_W-1:0] word_r;
  logic              accept_s;
  logic              hit_s;
  logic              last_word_s;

  assign accept_s    = (state_r == ST_IDLE) && miss_req;
  // Gating with reset_n keeps the hit path quiet while reset is held.
  assign hit_s       = (state_r == ST_IDLE) && hit_valid && reset_n;
  assign last_word_s = (word_r == LAST_WORD);

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   if (miss_req)  state_nxt_s = ST_VICTIM; else state_nxt_s = ST_IDLE;
      ST_VICTIM: if (rp_ready)  state_nxt_s = ST_REQ;    else state_nxt_s = ST_VICTIM;
      ST_REQ:    if (mem_gnt)   state_nxt_s = ST_WAIT;   else state_nxt_s = ST_REQ;
      ST_WAIT: begin
        if (mem_rvalid) state_nxt_s = last_word_s ? ST_COMMIT : ST_REQ;
        else            state_nxt_s = ST_WAIT;
      end
      ST_COMMIT: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Latched miss fields, victim way and word counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      set_r  <= '0;
      tag_r  <= '0;
      way_r  <= '0;
      word_r <= '0;
    end else begin
      if (accept_s) begin
        set_r  <= miss_addr[BYTE_W+WORD_W +: SET_W];
        tag_r  <= miss_addr[ADDR_W-1 -: TAG_W];
        word_r <= '0;
      end else if ((state_r == ST_WAIT) && mem_rvalid && !last_word_s) begin
        word_r <= word_r + WORD_W'(1);
      end
      if ((state_r == ST_VICTIM) && rp_ready) begin
        way_r <= rp_replacement_way;
      end
    end
  end

  // Output decode; every pulse and bus is zero outside its owning state.
  always_comb begin
    miss_ready = 1'b0;
    done       = 1'b0;
    rp_set     = '0;
    rp_way     = '0;
    rp_read    = 1'b0;
    rp_written = 1'b0;
    rp_taken   = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    line_we    = 1'b0;
    line_set   = '0;
    line_way   = '0;
    line_word  = '0;
    line_wdata = '0;
    tag_we     = 1'b0;
    tag_value  = '0;
    case (state_r)
      ST_IDLE: begin
        miss_ready = 1'b1;
        if (hit_s) begin
          rp_read = 1'b1;
          rp_set  = hit_set;
          rp_way  = hit_way;
        end else begin
          rp_read = 1'b0;
        end
      end
      ST_VICTIM: begin
        rp_set = set_r;
        if (rp_ready) rp_taken = 1'b1; else rp_taken = 1'b0;
      end
      ST_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {tag_r, set_r, word_r, 2'b00};
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          line_we    = 1'b1;
          line_set   = set_r;
          line_way   = way_r;
          line_word  = word_r;
          line_wdata = mem_rdata;
        end else begin
          line_we = 1'b0;
        end
      end
      ST_COMMIT: begin
        tag_we     = 1'b1;
        tag_value  = tag_r;
        rp_written = 1'b1;
        rp_set     = set_r;
        rp_way     = way_r;
        done       = 1'b1;
      end
      default: begin
        miss_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/cache_refill_controller.md
CACHE_REFILL_CONTROLLER -- requirements
Module: cache_refill_controller

Interface
REQ-001 SHALL have parameter WAY_COUNT, default 2: ways per set.
REQ-002 SHALL have parameter SET_COUNT, default 64: sets in the cache.
REQ-003 SHALL have parameter LINE_WORDS, default 4: 32-bit words per line, power of two.
REQ-004 SHALL have ports: clk  in  1  single clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 miss_req  in  1  core requests a line refill; miss_addr  in  32  byte address of the miss.
REQ-007 miss_ready  out  1  high only in IDLE; a miss is accepted when miss_req and miss_ready are both high.
REQ-008 done  out  1  one-cycle pulse when a refill is committed.
REQ-009 hit_valid  in  1  core hit this cycle; hit_set  in  log2(SET_COUNT)  set; hit_way  in  log2(WAY_COUNT)  way.
REQ-010 rp_set  out  log2(SET_COUNT); rp_way  out  log2(WAY_COUNT); rp_read, rp_written, rp_taken  out  1 each, single-cycle pulses.
REQ-011 rp_replacement_way  in  log2(WAY_COUNT); rp_ready  in  1  from the replacement policy.
REQ-012 mem_req  out  1; mem_addr  out  32  word-aligned; mem_gnt  in  1; mem_rvalid  in  1; mem_rdata  in  32.
REQ-013 line_we  out  1; line_set  out  log2(SET_COUNT); line_way  out  log2(WAY_COUNT); line_word  out  log2(LINE_WORDS); line_wdata  out  32.
REQ-014 tag_we  out  1; tag_value  out  32-log2(SET_COUNT)-log2(LINE_WORDS)-2.

Function
REQ-015 Address split SHALL be: bits [1:0] byte, next log2(LINE_WORDS) bits word, next log2(SET_COUNT) bits set, remaining upper bits tag.
REQ-016 FSM states SHALL be IDLE, VICTIM, REQ, WAIT, COMMIT.
REQ-017 IDLE: on accepted miss, latch set and tag, clear word counter, go to VICTIM next cycle.
REQ-018 IDLE: hit_valid SHALL produce rp_read=1 in the same cycle, with rp_set=hit_set and rp_way=hit_way. hit_valid in any other state SHALL be ignored.
REQ-019 When hit_valid and an accepted miss coincide in IDLE, both SHALL be honoured: rp_read pulses for the hit, and the miss is latched.
REQ-020 VICTIM: rp_set=latched set. While rp_ready=0, stay. When rp_ready=1, latch rp_replacement_way, pulse rp_taken for exactly that cycle, then go to REQ.
REQ-021 REQ: mem_req=1 and mem_addr={tag,set,word counter,2'b00}, held stable until mem_gnt=1; on the grant cycle go to WAIT.
REQ-022 WAIT: mem_req=0. On mem_rvalid, drive line_we=1 with the latched set, latched way, word counter and line_wdata=mem_rdata.
REQ-023 WAIT: on mem_rvalid, if the word counter = LINE_WORDS-1 go to COMMIT; else increment the counter and return to REQ.
REQ-024 At most one memory request SHALL be outstanding; mem_rvalid outside WAIT SHALL be ignored.
REQ-025 COMMIT: for one cycle, drive tag_we=1 with tag_value=latched tag, rp_written=1 with rp_set/rp_way=latched set/way, and done=1; then go to IDLE.
REQ-026 Words SHALL be fetched in ascending order 0..LINE_WORDS-1; word counter wraps only via reset of state, never modulo.
REQ-027 Minimum refill latency (rp_ready=1, mem_gnt same cycle, mem_rvalid next cycle) SHALL be 2+2*LINE_WORDS cycles from acceptance to done.
REQ-028 All pulse outputs (rp_read, rp_written, rp_taken, line_we, tag_we, done) SHALL be 0 outside the cycles defined above.

Reset
REQ-029 Asserting reset_n=0 SHALL immediately force IDLE and zero every output except miss_ready, which SHALL be 1.
REQ-030 Reset mid-refill SHALL abandon the line: no tag_we, rp_written or done; any late mem_rvalid after release is ignored.

Structure
REQ-031 Package cache_pkg SHALL hold the FSM state enum and the address-field width constants/functions shared with the cache top.
REQ-032 No sub-module; the replacement policy is instantiated by the cache top and connected to the rp_* ports.

Verification
REQ-033 Basic refill: miss_addr=0x0000_1230, rp_replacement_way=1, immediate gnt/rvalid -> rp_taken once, line_set=0x23, line_way=1, words 0..3 written in order, done at cycle 10.
REQ-034 Policy stall: rp_ready=0 for 5 cycles -> rp_taken and mem_req delayed exactly 5 cycles; rp_set=latched set throughout.
REQ-035 Memory backpressure: mem_gnt low 3 cycles per word -> mem_addr stable while waiting, mem_req never high in WAIT, exactly 4 line_we pulses.
REQ-036 Busy miss: a second miss_req during WAIT -> miss_ready=0 and not accepted; accepted the cycle after done.
REQ-037 Hits: hit_valid in IDLE with set 5 way 0 -> rp_read with rp_set=5; hit_valid during REQ -> no rp_read.
REQ-038 Reset in WAIT after word 1 -> outputs cleared, no done/tag_we; a following miss refills correctly from word 0.
